// File: rtl/pp_hop_extract.sv
// Splits path words into per-record hop info and writes it into ping-pong hop FIFOs.
// Optional per-path record cap (MAX_HOPS) is enabled by defining PP_HOP_EXTRACT_MAX_HOPS_EN.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif
`ifndef PP_META_RCI_NBITS
`define PP_META_RCI_NBITS 8
`endif
`ifndef HOP_INFO_RCI_NBITS
`define HOP_INFO_RCI_NBITS 8
`endif
`ifndef HOP_INFO_BYTE_POINTER_NBITS
`define HOP_INFO_BYTE_POINTER_NBITS 10
`endif
`ifndef HOP_INFO_NBITS
`define HOP_INFO_NBITS (3 + `HOP_INFO_RCI_NBITS + `HOP_INFO_BYTE_POINTER_NBITS)
`endif

module pp_hop_extract #(
  parameter int MAX_HOPS = 32
) (
  input  logic                          clk,
  input  logic                          `RESET_SIG,
  input  logic                          path_valid,
  output logic                          path_ready,
  input  logic                          path_sop,
  input  logic                          path_eop,
  input  logic [63:0]                   path_data,
  input  logic [7:0]                    path_len,
  input  logic [`PP_META_RCI_NBITS-1:0] path_rci,
  output logic                          pp_meta_valid,
  output logic [`PP_META_RCI_NBITS-1:0] pp_meta_rci,
  output logic                          hop_fifo_reset0,
  output logic                          hop_fifo_reset1,
  output logic                          hop_fifo_wr0,
  output logic                          hop_fifo_wr1,
  output logic                          hop_fifo_eop0,
  output logic                          hop_fifo_eop1,
  output logic [`HOP_INFO_NBITS-1:0]    hop_fifo_wdata0,
  output logic [`HOP_INFO_NBITS-1:0]    hop_fifo_wdata1,
  input  logic                          hop_fifo_full0,
  input  logic                          hop_fifo_full1,
  input  logic                          parse_done0,
  input  logic                          parse_done1,
  output logic [15:0]                   err_cnt
);
  localparam int RW = `HOP_INFO_RCI_NBITS;
  localparam int BW = `HOP_INFO_BYTE_POINTER_NBITS;
  localparam int HW = `HOP_INFO_NBITS;

  typedef enum logic [1:0] {IDLE, HOP0, HOP1, GET} state_t;

  state_t      state_q, state_d;
  logic        wptr_q, wptr_d;
  logic [1:0]  busy_q, busy_d;
  logic [15:0] err_q, err_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  len_q, len_d;
  logic [63:0] hold_q, hold_d;
  logic        eop_seen_q, eop_seen_d;
  logic        drop_q, drop_d;

  logic          rst_w;
  logic          ready_w, fifo_rst, fifo_wr, fifo_eop, meta_vld;
  logic          fifo_full, last_rec, word_final, trunc, set_busy;
  logic [1:0]    err_inc;
  logic [16:0]   err_sum;
  logic [31:0]   rec;
  logic [BW-1:0] bp;
  logic [HW-1:0] wdata;

  assign rst_w = `RESET_SIG;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    busy_d     = busy_q;
    idx_d      = idx_q;
    len_d      = len_q;
    hold_d     = hold_q;
    eop_seen_d = eop_seen_q;
    drop_d     = drop_q;
    ready_w    = 1'b0;
    fifo_rst   = 1'b0;
    fifo_wr    = 1'b0;
    fifo_eop   = 1'b0;
    meta_vld   = 1'b0;
    set_busy   = 1'b0;
    err_inc    = 2'd0;
    trunc      = 1'b0;
    rec        = (state_q == HOP1) ? hold_q[31:0] : hold_q[63:32];
    bp         = BW'({idx_q, 2'b00});
    wdata      = {rec[31:29], rec[RW-1:0], bp};
    fifo_full  = wptr_q ? hop_fifo_full1 : hop_fifo_full0;
    word_final = ({1'b0, idx_q} + 9'd2 >= {1'b0, len_q});
`ifdef PP_HOP_EXTRACT_MAX_HOPS_EN
    trunc      = (int'(len_q) > MAX_HOPS) && (int'(idx_q) + 1 >= MAX_HOPS);
`endif
    // len 0 is illegal; treating record 0 as last keeps the FSM from running away
    last_rec   = ({1'b0, idx_q} + 9'd1 >= {1'b0, len_q}) | trunc;

    case (state_q)
      IDLE: begin
        ready_w = ~busy_q[wptr_q];
        if (path_valid && ready_w) begin
          if (path_sop) begin
            fifo_rst   = 1'b1;
            meta_vld   = 1'b1;
            hold_d     = path_data;
            len_d      = path_len;
            idx_d      = 8'd0;
            eop_seen_d = path_eop;
            drop_d     = 1'b0;
            state_d    = HOP0;
            if (path_eop && (path_len > 8'd2)) err_inc = 2'd1;
          end else begin
            if (!drop_q) err_inc = 2'd1;
            if (path_eop) drop_d = 1'b0;
          end
        end
      end
      HOP0, HOP1: begin
        if (!fifo_full) begin
          fifo_wr  = 1'b1;
          fifo_eop = last_rec;
          idx_d    = idx_q + 8'd1;
          if (last_rec) begin
            set_busy = 1'b1;
            wptr_d   = ~wptr_q;
            state_d  = IDLE;
`ifdef PP_HOP_EXTRACT_MAX_HOPS_EN
            // Truncated path: the rest of it up to path_eop is dropped silently
            if (trunc) begin
              err_inc = 2'd1;
              drop_d  = ~eop_seen_q;
            end
`endif
          end else begin
            state_d = (state_q == HOP0) ? HOP1 : GET;
          end
        end
      end
      GET: begin
        ready_w = 1'b1;
        if (path_valid) begin
          hold_d     = path_data;
          eop_seen_d = eop_seen_q | path_eop;
          state_d    = HOP0;
          err_inc    = 2'(path_sop) + 2'(path_eop && !word_final);
        end
      end
      default: state_d = IDLE;
    endcase

    if (set_busy) busy_d[wptr_q] = 1'b1;
    if (parse_done0) busy_d[0] = 1'b0;
    if (parse_done1) busy_d[1] = 1'b0;

    err_sum = {1'b0, err_q} + 17'(err_inc);
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst_w) begin
      state_q    <= IDLE;
      wptr_q     <= 1'b0;
      busy_q     <= 2'b00;
      err_q      <= 16'd0;
      idx_q      <= 8'd0;
      len_q      <= 8'd0;
      hold_q     <= 64'd0;
      eop_seen_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      hold_q     <= hold_d;
      eop_seen_q <= eop_seen_d;
      drop_q     <= drop_d;
    end
  end

  assign path_ready      = ready_w;
  assign pp_meta_valid   = meta_vld & ~rst_w;
  assign pp_meta_rci     = pp_meta_valid ? path_rci : '0;
  assign hop_fifo_reset0 = fifo_rst & ~rst_w & ~wptr_q;
  assign hop_fifo_reset1 = fifo_rst & ~rst_w & wptr_q;
  assign hop_fifo_wr0    = fifo_wr & ~rst_w & ~wptr_q;
  assign hop_fifo_wr1    = fifo_wr & ~rst_w & wptr_q;
  assign hop_fifo_eop0   = hop_fifo_wr0 & fifo_eop;
  assign hop_fifo_eop1   = hop_fifo_wr1 & fifo_eop;
  assign hop_fifo_wdata0 = hop_fifo_wr0 ? wdata : '0;
  assign hop_fifo_wdata1 = hop_fifo_wr1 ? wdata : '0;
  assign err_cnt         = err_q;

  logic unused_bits;
`ifdef PP_HOP_EXTRACT_MAX_HOPS_EN
  assign unused_bits = ^{hold_q[60:32+RW], hold_q[28:RW]};
`else
  assign unused_bits = ^{hold_q[60:32+RW], hold_q[28:RW], MAX_HOPS};
`endif

endmodule

// File: tb/tb_pp_hop_extract.sv
// Directed bench for pp_hop_extract: per-cycle vector table plus handshake-driven corner sequences.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif
`ifndef PP_META_RCI_NBITS
`define PP_META_RCI_NBITS 8
`endif
`ifndef HOP_INFO_RCI_NBITS
`define HOP_INFO_RCI_NBITS 8
`endif
`ifndef HOP_INFO_BYTE_POINTER_NBITS
`define HOP_INFO_BYTE_POINTER_NBITS 10
`endif
`ifndef HOP_INFO_NBITS
`define HOP_INFO_NBITS (3 + `HOP_INFO_RCI_NBITS + `HOP_INFO_BYTE_POINTER_NBITS)
`endif

module tb_pp_hop_extract;
  localparam int HW = `HOP_INFO_NBITS;
  localparam int MW = `PP_META_RCI_NBITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          path_valid = 1'b0, path_sop = 1'b0, path_eop = 1'b0;
  logic [63:0]   path_data = '0;
  logic [7:0]    path_len = '0;
  logic [MW-1:0] path_rci = '0;
  logic          hop_fifo_full0 = 1'b0, hop_fifo_full1 = 1'b0;
  logic          parse_done0 = 1'b0, parse_done1 = 1'b0;
  logic          path_ready, pp_meta_valid;
  logic [MW-1:0] pp_meta_rci;
  logic          hop_fifo_reset0, hop_fifo_reset1, hop_fifo_wr0, hop_fifo_wr1;
  logic          hop_fifo_eop0, hop_fifo_eop1;
  logic [HW-1:0] hop_fifo_wdata0, hop_fifo_wdata1;
  logic [15:0]   err_cnt;

  always #5 clk = ~clk;

  pp_hop_extract #(.MAX_HOPS(4)) dut (
    .clk(clk), .`RESET_SIG(rst),
    .path_valid(path_valid), .path_ready(path_ready),
    .path_sop(path_sop), .path_eop(path_eop), .path_data(path_data),
    .path_len(path_len), .path_rci(path_rci),
    .pp_meta_valid(pp_meta_valid), .pp_meta_rci(pp_meta_rci),
    .hop_fifo_reset0(hop_fifo_reset0), .hop_fifo_reset1(hop_fifo_reset1),
    .hop_fifo_wr0(hop_fifo_wr0), .hop_fifo_wr1(hop_fifo_wr1),
    .hop_fifo_eop0(hop_fifo_eop0), .hop_fifo_eop1(hop_fifo_eop1),
    .hop_fifo_wdata0(hop_fifo_wdata0), .hop_fifo_wdata1(hop_fifo_wdata1),
    .hop_fifo_full0(hop_fifo_full0), .hop_fifo_full1(hop_fifo_full1),
    .parse_done0(parse_done0), .parse_done1(parse_done1),
    .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write log: {fifo, eop, wdata} per observed FIFO write
  logic [31:0] got[$];
  logic        mon_en = 1'b0;
  int          both_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (hop_fifo_wr0 && hop_fifo_wr1) both_cnt++;
      if (hop_fifo_wr0) got.push_back(32'({1'b0, hop_fifo_eop0, hop_fifo_wdata0}));
      if (hop_fifo_wr1) got.push_back(32'({1'b1, hop_fifo_eop1, hop_fifo_wdata1}));
    end
  end

  function automatic logic [31:0] ew(input logic f, input logic e, input logic [31:0] r, input int idx);
    logic [9:0] bp;
    bp = 10'(idx * 4);
    return 32'({f, e, r[31:29], r[7:0], bp});
  endfunction

  task automatic check_log(input string tag, input logic [31:0] exp_q[$]);
    chk({tag, " nwrites"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s write%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic send_word(input logic sop, input logic eop, input logic [63:0] dat,
                           input logic [7:0] len, input logic [MW-1:0] rci);
    int n;
    path_valid = 1'b1; path_sop = sop; path_eop = eop;
    path_data = dat; path_len = len; path_rci = rci;
    n = 0;
    @(negedge clk);
    while (!path_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("handshake timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    path_valid = 1'b0; path_sop = 1'b0; path_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    got.delete();
  endtask

  typedef struct {
    logic rst, vld, sop, eop;
    logic [63:0] dat;
    logic [7:0] len;
    logic [7:0] rci;
    logic f0, f1, pd0, pd1;
    logic e_rdy, e_wr0, e_wr1, e_eop0, e_eop1, e_rst0, e_rst1, e_meta;
    logic [31:0] e_wd;
    logic [15:0] e_err;
  } vec_t;

  localparam logic [31:0] R0 = 32'h3ABC_DE11, R1 = 32'h5555_5522, R2 = 32'h7000_0033;
  localparam logic [31:0] R3 = 32'hFFFF_FFFF, RA = 32'h2000_0041, RB = 32'hE000_00F0;
  localparam logic [31:0] RC = 32'h4000_0007;

  vec_t tv[16];
  logic [31:0] exp_q[$];
  logic [31:0] a[6];

  initial begin
    // rst vld sop eop data len rci | f0 f1 pd0 pd1 | rdy wr0 wr1 eop0 eop1 rst0 rst1 meta | wdata err
    tv[0]  = '{1,0,0,0, 64'h0,      0, 8'h00, 0,0,0,0, 1,0,0,0,0,0,0,0, 32'h0,      16'd0};
    tv[1]  = '{0,1,1,0, {R0, R1},   3, 8'h5A, 0,0,0,0, 1,0,0,0,0,1,0,1, 32'h0,      16'd0};
    tv[2]  = '{0,1,0,1, {R2, R3},   0, 8'h00, 0,0,0,0, 0,1,0,0,0,0,0,0, 32'h44400,  16'd0};
    tv[3]  = '{0,1,0,1, {R2, R3},   0, 8'h00, 0,0,0,0, 0,1,0,0,0,0,0,0, 32'h88804,  16'd0};
    tv[4]  = '{0,1,0,1, {R2, R3},   0, 8'h00, 0,0,0,0, 1,0,0,0,0,0,0,0, 32'h0,      16'd0};
    tv[5]  = '{0,0,0,0, 64'h0,      0, 8'h00, 0,0,0,0, 0,1,0,1,0,0,0,0, 32'hCCC08,  16'd0};
    tv[6]  = '{0,0,0,0, 64'h0,      0, 8'h00, 0,0,0,0, 1,0,0,0,0,0,0,0, 32'h0,      16'd0};
    tv[7]  = '{0,1,1,1, {RA, RB},   2, 8'h33, 0,0,0,0, 1,0,0,0,0,0,1,1, 32'h0,      16'd0};
    tv[8]  = '{0,0,0,0, 64'h0,      0, 8'h00, 0,0,0,0, 0,0,1,0,0,0,0,0, 32'h50400,  16'd0};
    tv[9]  = '{0,0,0,0, 64'h0,      0, 8'h00, 0,0,0,0, 0,0,1,0,1,0,0,0, 32'h1FC004, 16'd0};
    tv[10] = '{0,1,1,1, {RC, 32'h0},1, 8'h77, 0,0,0,0, 0,0,0,0,0,0,0,0, 32'h0,      16'd0};
    tv[11] = '{0,1,1,1, {RC, 32'h0},1, 8'h77, 0,0,1,0, 0,0,0,0,0,0,0,0, 32'h0,      16'd0};
    tv[12] = '{0,1,1,1, {RC, 32'h0},1, 8'h77, 0,0,0,0, 1,0,0,0,0,1,0,1, 32'h0,      16'd0};
    tv[13] = '{0,0,0,0, 64'h0,      0, 8'h00, 0,0,0,0, 0,1,0,1,0,0,0,0, 32'h81C00,  16'd0};
    tv[14] = '{0,0,0,0, 64'h0,      0, 8'h00, 0,0,1,1, 0,0,0,0,0,0,0,0, 32'h0,      16'd0};
    tv[15] = '{0,0,0,0, 64'h0,      0, 8'h00, 0,0,0,0, 1,0,0,0,0,0,0,0, 32'h0,      16'd0};
    for (int i = 0; i < 6; i++) a[i] = {3'(i + 1), 5'h0A, 16'h5A5A, 8'(8'h10 + i)};

    idle(2);
    for (int i = 0; i < 16; i++) begin
      rst = tv[i].rst; path_valid = tv[i].vld; path_sop = tv[i].sop; path_eop = tv[i].eop;
      path_data = tv[i].dat; path_len = tv[i].len; path_rci = tv[i].rci;
      hop_fifo_full0 = tv[i].f0; hop_fifo_full1 = tv[i].f1;
      parse_done0 = tv[i].pd0; parse_done1 = tv[i].pd1;
      @(negedge clk);
      chk($sformatf("v%0d ready", i), path_ready, tv[i].e_rdy);
      chk($sformatf("v%0d wr0", i), hop_fifo_wr0, tv[i].e_wr0);
      chk($sformatf("v%0d wr1", i), hop_fifo_wr1, tv[i].e_wr1);
      chk($sformatf("v%0d eop0", i), hop_fifo_eop0, tv[i].e_eop0);
      chk($sformatf("v%0d eop1", i), hop_fifo_eop1, tv[i].e_eop1);
      chk($sformatf("v%0d wdata0", i), hop_fifo_wdata0, tv[i].e_wr0 ? tv[i].e_wd : 32'h0);
      chk($sformatf("v%0d wdata1", i), hop_fifo_wdata1, tv[i].e_wr1 ? tv[i].e_wd : 32'h0);
      chk($sformatf("v%0d fifo_reset0", i), hop_fifo_reset0, tv[i].e_rst0);
      chk($sformatf("v%0d fifo_reset1", i), hop_fifo_reset1, tv[i].e_rst1);
      chk($sformatf("v%0d meta_valid", i), pp_meta_valid, tv[i].e_meta);
      chk($sformatf("v%0d meta_rci", i), pp_meta_rci, tv[i].e_meta ? tv[i].rci : 8'h00);
      chk($sformatf("v%0d err_cnt", i), err_cnt, tv[i].e_err);
      @(posedge clk); #1;
    end
    path_valid = 1'b0; parse_done0 = 1'b0; parse_done1 = 1'b0;

    // full0 stall mid-path, odd length: record1 of the last word is discarded
    do_reset();
    mon_en = 1'b1;
    send_word(1'b1, 1'b0, {a[0], a[1]}, 8'd5, 8'h21);
    @(negedge clk);
    @(posedge clk); #1;
    hop_fifo_full0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d wr0", i), hop_fifo_wr0, 1'b0);
      @(posedge clk); #1;
    end
    hop_fifo_full0 = 1'b0;
    send_word(1'b0, 1'b0, {a[2], a[3]}, 8'd0, 8'h00);
    send_word(1'b0, 1'b1, {a[4], a[5]}, 8'd0, 8'h00);
    idle(4);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(ew(1'b0, i == 4, a[i], i));
    check_log("stall", exp_q);
    chk("stall err_cnt", err_cnt, 16'd0);

    // stray non-sop word in IDLE, then a path whose first word carries an early eop
    do_reset();
    send_word(1'b0, 1'b0, {a[5], a[5]}, 8'd0, 8'h00);
    send_word(1'b1, 1'b1, {a[0], a[1]}, 8'd4, 8'h01);
    send_word(1'b0, 1'b0, {a[2], a[3]}, 8'd0, 8'h00);
    idle(5);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(ew(1'b0, i == 3, a[i], i));
    check_log("proto_err", exp_q);
    chk("proto_err err_cnt", err_cnt, 16'd2);

`ifdef PP_HOP_EXTRACT_MAX_HOPS_EN
    do_reset();
    send_word(1'b1, 1'b0, {a[0], a[1]}, 8'd7, 8'h02);
    send_word(1'b0, 1'b0, {a[2], a[3]}, 8'd0, 8'h00);
    send_word(1'b0, 1'b0, {a[4], a[5]}, 8'd0, 8'h00);
    send_word(1'b0, 1'b1, {a[0], a[0]}, 8'd0, 8'h00);
    idle(4);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(ew(1'b0, i == 3, a[i], i));
    check_log("max_hops", exp_q);
    chk("max_hops err_cnt", err_cnt, 16'd1);
`endif

    // reset while in HOP1 abandons the path; next path starts cleanly in FIFO0
    do_reset();
    send_word(1'b1, 1'b0, {a[0], a[1]}, 8'd4, 8'h03);
    @(negedge clk);
    @(posedge clk); #1;
    parse_done1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("in_reset wr0", hop_fifo_wr0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset ready", path_ready, 1'b1);
    chk("post_reset wr0", hop_fifo_wr0, 1'b0);
    chk("post_reset wr1", hop_fifo_wr1, 1'b0);
    chk("post_reset meta_valid", pp_meta_valid, 1'b0);
    chk("post_reset fifo_reset0", hop_fifo_reset0, 1'b0);
    chk("post_reset err_cnt", err_cnt, 16'd0);
    @(posedge clk); #1;
    got.delete();
    send_word(1'b1, 1'b1, {a[4], a[5]}, 8'd2, 8'h04);
    idle(4);
    exp_q.delete();
    exp_q.push_back(ew(1'b0, 1'b0, a[4], 0));
    exp_q.push_back(ew(1'b0, 1'b1, a[5], 1));
    check_log("after_reset", exp_q);
    chk("one fifo per cycle", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
